// File: rtl/record_pkg.sv
// Shared types and constants for the record reader: default geometry, record
// field layout and the fetch FSM state encoding.
package record_pkg;

  localparam int unsigned AddrWDef = 4;
  localparam int unsigned DepthDef = 16;

  localparam int unsigned RecW = 14;
  localparam int unsigned OptW = 3;

  localparam int unsigned D1Msb = 13;
  localparam int unsigned D1Lsb = 10;
  localparam int unsigned D2Msb = 9;
  localparam int unsigned D2Lsb = 7;
  localparam int unsigned D3Msb = 6;
  localparam int unsigned D3Lsb = 3;
  localparam int unsigned D4Msb = 2;
  localparam int unsigned D4Lsb = 0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StLatch,
    StShow
  } state_e;

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector; the previous sample resets to 0.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/record_reader.sv
// Browses stored timer records: snoops the record RAM write port to track the
// record count, fetches the selected entry from both RAMs and holds it on the displays.
module record_reader
  import record_pkg::*;
#(
  parameter int unsigned ADDR_W      = AddrWDef,
  parameter int unsigned DEPTH       = DepthDef,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              clear,
  input  logic              next,
  input  logic              prev,
  input  logic              play,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [RecW-1:0]   rd_data,
  input  logic [OptW-1:0]   rd_data2,
  output logic [3:0]        disp1,
  output logic [2:0]        disp2,
  output logic [3:0]        disp3,
  output logic [2:0]        disp4,
  output logic [OptW-1:0]   opt,
  output logic [ADDR_W-1:0] idx,
  output logic [ADDR_W:0]   count,
  output logic              valid
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [HoldW-1:0]  HoldOne  = {{(HoldW - 1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IdxOne   = {{(ADDR_W - 1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CntOne   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CountMax = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [RecW-1:0]   rec_q, rec_d;
  logic [OptW-1:0]   opt_q, opt_d;
  logic              valid_q, valid_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              tick_q, tick_d;

  logic next_rise, prev_rise, play_rise;

  edge_detect u_next_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (next),
    .rise_o (next_rise)
  );

  edge_detect u_prev_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (prev),
    .rise_o (prev_rise)
  );

  edge_detect u_play_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (play),
    .rise_o (play_rise)
  );

  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W-1:0] idx_fwd, idx_back;
  logic              step_fwd, step_back, refetch;

  always_comb begin
    wr_cnt    = {1'b0, addr} + CntOne;
    idx_inc   = {1'b0, idx_q} + CntOne;
    idx_fwd   = (idx_inc == count_q) ? '0 : idx_q + IdxOne;
    // count_q[ADDR_W-1:0] wraps to 0 when full, so subtracting one still lands on DEPTH-1.
    idx_back  = (idx_q == '0) ? count_q[ADDR_W-1:0] - IdxOne : idx_q - IdxOne;
    step_back = prev_rise & ~next_rise;
    step_fwd  = (next_rise & ~prev_rise) | (tick_q & play);
    refetch   = wr_en && (addr == idx_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    rec_d   = rec_q;
    opt_d   = opt_q;
    valid_d = valid_q;
    hold_d  = '0;
    tick_d  = 1'b0;

    if (wr_en && ({1'b0, addr} >= count_q)) begin
      count_d = (wr_cnt > CountMax) ? CountMax : wr_cnt;
    end

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        rec_d   = rd_data;
        opt_d   = rd_data2;
        valid_d = 1'b1;
        state_d = StShow;
      end
      StShow: begin
        if (step_back) begin
          idx_d   = idx_back;
          state_d = StFetch;
        end else if (step_fwd) begin
          idx_d   = idx_fwd;
          state_d = StFetch;
        end else if (refetch) begin
          state_d = StFetch;
        end else if (play && !play_rise) begin
          // Terminal count arms a tick; the step itself fires on the following cycle.
          if (hold_q == HoldLast) begin
            tick_d = 1'b1;
          end else begin
            hold_d = hold_q + HoldOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      state_d = StIdle;
      idx_d   = '0;
      count_d = '0;
      rec_d   = '0;
      opt_d   = '0;
      valid_d = 1'b0;
      hold_d  = '0;
      tick_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      count_q <= '0;
      rec_q   <= '0;
      opt_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      rec_q   <= rec_d;
      opt_q   <= opt_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      tick_q  <= tick_d;
    end
  end

  assign rd_en   = (state_q == StFetch);
  assign rd_addr = idx_q;
  assign disp1   = rec_q[D1Msb:D1Lsb];
  assign disp2   = rec_q[D2Msb:D2Lsb];
  assign disp3   = rec_q[D3Msb:D3Lsb];
  assign disp4   = rec_q[D4Msb:D4Lsb];
  assign opt     = opt_q;
  assign idx     = idx_q;
  assign count   = count_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_record_reader.sv
// Directed bench for record_reader with behavioural record/option RAMs and a
// scoreboard of expected displayed entries.
module tb_record_reader;

  localparam int unsigned HOLD = 8;

  logic        clk = 1'b0;
  logic        rst, wr_en, clear, next, prev, play;
  logic [3:0]  addr;
  logic [13:0] wdata;
  logic [2:0]  wdata2;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [13:0] rd_data = '0;
  logic [2:0]  rd_data2 = '0;
  logic [3:0]  disp1, disp3;
  logic [2:0]  disp2, disp4, opt;
  logic [3:0]  idx;
  logic [4:0]  count;
  logic        valid;

  logic [13:0] mem  [16];
  logic [2:0]  mem2 [16];
  logic [13:0] sh_rec [16];
  logic [2:0]  sh_opt [16];

  typedef struct packed {
    logic [3:0]  idx;
    logic [13:0] rec;
    logic [2:0]  opt;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int rd_pulses = 0;
  int m_cnt = 0;
  logic [3:0] m_idx = '0;

  record_reader #(
    .ADDR_W      (4),
    .DEPTH       (16),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .addr     (addr),
    .clear    (clear),
    .next     (next),
    .prev     (prev),
    .play     (play),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_data2 (rd_data2),
    .disp1    (disp1),
    .disp2    (disp2),
    .disp3    (disp3),
    .disp4    (disp4),
    .opt      (opt),
    .idx      (idx),
    .count    (count),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) begin
      mem[addr]  <= wdata;
      mem2[addr] <= wdata2;
    end
    if (rd_en) begin
      rd_data  <= mem[rd_addr];
      rd_data2 <= mem2[rd_addr];
    end
  end

  always @(negedge clk) if (rd_en === 1'b1) rd_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] fwd(input logic [3:0] i, input int c);
    return (int'(i) + 1 == c) ? 4'd0 : i + 4'd1;
  endfunction

  function automatic logic [3:0] back(input logic [3:0] i, input int c);
    return (i == 4'd0) ? 4'(c - 1) : i - 4'd1;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [13:0] d, input logic [2:0] o);
    wr_en     = 1'b1;
    addr      = a;
    wdata     = d;
    wdata2    = o;
    sh_rec[a] = d;
    sh_opt[a] = o;
    if (int'(a) >= m_cnt) m_cnt = int'(a) + 1;
  endtask

  task automatic push_exp(input logic [3:0] i);
    sb.push_back('{idx: i, rec: sh_rec[i], opt: sh_opt[i]});
  endtask

  task automatic check_disp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_idx"}, 32'(idx), 32'(e.idx));
      chk({tag, "_d1"}, 32'(disp1), 32'(e.rec[13:10]));
      chk({tag, "_d2"}, 32'(disp2), 32'(e.rec[9:7]));
      chk({tag, "_d3"}, 32'(disp3), 32'(e.rec[6:3]));
      chk({tag, "_d4"}, 32'(disp4), 32'(e.rec[2:0]));
      chk({tag, "_opt"}, 32'(opt), 32'(e.opt));
      chk({tag, "_valid"}, 32'(valid), 32'd1);
    end
  endtask

  task automatic step(input logic n, input logic p, input string tag);
    m_idx = n ? fwd(m_idx, m_cnt) : back(m_idx, m_cnt);
    push_exp(m_idx);
    next = n;
    prev = p;
    cyc();
    chk({tag, "_idx_t1"}, 32'(idx), 32'(m_idx));
    chk({tag, "_rden_t1"}, 32'(rd_en), 32'd1);
    next = 1'b0;
    prev = 1'b0;
    cyc();
    cyc();
    check_disp(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_d1"}, 32'(disp1), 32'd0);
    chk({tag, "_d2"}, 32'(disp2), 32'd0);
    chk({tag, "_d3"}, 32'(disp3), 32'd0);
    chk({tag, "_d4"}, 32'(disp4), 32'd0);
    chk({tag, "_opt"}, 32'(opt), 32'd0);
    chk({tag, "_idx"}, 32'(idx), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int pulses;
    int t;
    int k;
    int last;
    logic [3:0] seen;

    rst = 1'b0; wr_en = 1'b0; clear = 1'b0; next = 1'b0; prev = 1'b0; play = 1'b0;
    addr = '0; wdata = '0; wdata2 = '0;
    cyc();
    cyc();
    check_zero("reset");

    // First three records; display of entry 0 appears four cycles after the first write.
    rst = 1'b1;
    wr(4'd0, 14'h1A5B, 3'd5);
    push_exp(4'd0);
    cyc();
    chk("count_t1", 32'(count), 32'd1);
    chk("rden_t1", 32'(rd_en), 32'd0);
    wr(4'd1, 14'h0000, 3'd1);
    cyc();
    chk("rden_t2", 32'(rd_en), 32'd1);
    chk("rdaddr_t2", 32'(rd_addr), 32'd0);
    chk("count_t2", 32'(count), 32'd2);
    wr(4'd2, 14'h3FFF, 3'd7);
    cyc();
    chk("valid_t3", 32'(valid), 32'd0);
    wr_en = 1'b0;
    cyc();
    check_disp("first");
    chk("count_3", 32'(count), 32'(m_cnt));

    step(1'b1, 1'b0, "next1");
    step(1'b1, 1'b0, "next2");
    step(1'b1, 1'b0, "next_wrap");
    step(1'b0, 1'b1, "prev_wrap");

    pulses = rd_pulses;
    next = 1'b1;
    prev = 1'b1;
    cyc();
    next = 1'b0;
    prev = 1'b0;
    cyc(); cyc(); cyc();
    chk("cancel_pulses", 32'(rd_pulses), 32'(pulses));
    chk("cancel_idx", 32'(idx), 32'(m_idx));

    // Overwrite the displayed entry: one refetch, new value three cycles later.
    pulses = rd_pulses;
    wr(m_idx, 14'h0123, 3'd2);
    push_exp(m_idx);
    cyc();
    chk("refetch_rden", 32'(rd_en), 32'd1);
    wr_en = 1'b0;
    cyc();
    cyc();
    check_disp("refetch");
    chk("refetch_pulses", 32'(rd_pulses), 32'(pulses + 1));
    chk("refetch_count", 32'(count), 32'd3);

    play = 1'b1;
    t = 0;
    k = 0;
    last = -1;
    seen = idx;
    while (k < 4 && t < 200) begin
      cyc();
      t++;
      if (idx !== seen) begin
        seen = idx;
        m_idx = fwd(m_idx, m_cnt);
        chk("play_idx", 32'(idx), 32'(m_idx));
        if (last >= 0) chk("play_gap", 32'(t - last), 32'(HOLD + 3));
        last = t;
        k++;
      end
    end
    if (k < 4) begin
      n_cmp++;
      n_bad++;
      $error("FAIL play_timeout: observed %0d steps expected 4", k);
    end
    play = 1'b0;
    push_exp(m_idx);
    cyc();
    cyc();
    check_disp("play_end");

    // Clear while a fetch is in flight.
    next = 1'b1;
    cyc();
    next = 1'b0;
    clear = 1'b1;
    cyc();
    check_zero("clear");
    pulses = rd_pulses;
    cyc(); cyc();
    clear = 1'b0;
    cyc(); cyc(); cyc();
    chk("clear_no_read", 32'(rd_pulses), 32'(pulses));
    m_cnt = 0;
    m_idx = '0;

    wr(4'd0, 14'h1A5B, 3'd5);
    push_exp(4'd0);
    cyc();
    wr_en = 1'b0;
    cyc(); cyc(); cyc();
    check_disp("refill");

    play = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    cyc();
    check_zero("rst_mid_play");
    rst = 1'b1;
    play = 1'b0;
    pulses = rd_pulses;
    cyc(); cyc(); cyc(); cyc();
    chk("rst_no_read", 32'(rd_pulses), 32'(pulses));
    chk("rst_valid", 32'(valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
